// File: rtl/traceback_unit.sv
// Needleman-Wunsch traceback: walks the score matrix from (len_a,len_b) back to (0,0)
// and emits one alignment op per step, re-deriving each move from neighbours and chars.
module traceback_unit #(
    parameter int              N        = 128,
    parameter int              BitAddr  = $clog2(N),
    parameter int              CHAR_W   = 2,
    parameter logic signed [8:0] MATCH    = 9'sd1,
    parameter logic signed [8:0] MISMATCH = -9'sd1,
    parameter logic signed [8:0] GAP      = -9'sd1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [BitAddr:0]    len_a,
    input  logic [BitAddr:0]    len_b,
    input  logic signed [8:0]   score_in,
    output logic                en_ins_read,
    output logic                we,
    output logic [BitAddr:0]    i,
    output logic [BitAddr:0]    j,
    input  logic signed [8:0]   diag,
    input  logic signed [8:0]   up,
    input  logic signed [8:0]   left,
    output logic [BitAddr:0]    addr_a,
    output logic [BitAddr:0]    addr_b,
    input  logic [CHAR_W-1:0]   char_a,
    input  logic [CHAR_W-1:0]   char_b,
    output logic [1:0]          op,
    output logic                op_valid,
    input  logic                op_ready,
    output logic                busy,
    output logic                done,
    output logic                err
);
    localparam int              IW      = BitAddr + 1;
    localparam logic [IW-1:0]   ONE     = IW'(1);
    localparam logic [1:0]      OP_DM   = 2'b00;
    localparam logic [1:0]      OP_DX   = 2'b01;
    localparam logic [1:0]      OP_UP   = 2'b10;
    localparam logic [1:0]      OP_LEFT = 2'b11;

    typedef enum logic [2:0] {IDLE, REQ, CAPT, EMIT, DONE} state_t;

    state_t            state;
    logic signed [8:0] cur;
    logic signed [8:0] next_cur;

    logic [IW-1:0]     step_i, step_j, tgt_i, tgt_j;
    logic signed [8:0] tgt_cur, edge_cur, s;
    logic [9:0]        cur_x, sum_d, sum_u, sum_l;
    logic              chars_eq, advance;
    logic [1:0]        diag_op;

    assign we = 1'b0;

    // Target cell/score for the next step: the start cell from IDLE, or the
    // neighbour selected by the op being accepted in EMIT.
    always_comb begin
        step_i = i;
        step_j = j;
        case (op)
            OP_DM, OP_DX: begin step_i = i - ONE; step_j = j - ONE; end
            OP_UP:        step_i = i - ONE;
            default:      step_j = j - ONE;
        endcase
        tgt_i    = (state == IDLE) ? len_a : step_i;
        tgt_j    = (state == IDLE) ? len_b : step_j;
        tgt_cur  = (state == IDLE) ? score_in : next_cur;
        edge_cur = tgt_cur - GAP;
        chars_eq = (char_a == char_b);
        s        = chars_eq ? MATCH : MISMATCH;
        diag_op  = chars_eq ? OP_DM : OP_DX;
        cur_x    = {cur[8], cur};
        sum_d    = {diag[8], diag} + {s[8], s};
        sum_u    = {up[8], up} + {GAP[8], GAP};
        sum_l    = {left[8], left} + {GAP[8], GAP};
        advance  = ((state == IDLE) && start) || ((state == EMIT) && op_ready);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cur         <= '0;
            next_cur    <= '0;
            i           <= '0;
            j           <= '0;
            addr_a      <= '0;
            addr_b      <= '0;
            op          <= '0;
            op_valid    <= 1'b0;
            en_ins_read <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else if (advance) begin
            i   <= tgt_i;
            j   <= tgt_j;
            cur <= tgt_cur;
            if (state == IDLE) begin
                err  <= 1'b0;
                busy <= 1'b1;
            end
            if (tgt_i == '0 && tgt_j == '0) begin
                state    <= DONE;
                done     <= 1'b1;
                busy     <= 1'b0;
                op_valid <= 1'b0;
            end else if (tgt_i != '0 && tgt_j != '0) begin
                state       <= REQ;
                en_ins_read <= 1'b1;
                addr_a      <= tgt_i - ONE;
                addr_b      <= tgt_j - ONE;
                op_valid    <= 1'b0;
            end else begin
                // Matrix edge: the move is forced, so skip the RAM entirely.
                state    <= EMIT;
                op       <= (tgt_i == '0) ? OP_LEFT : OP_UP;
                op_valid <= 1'b1;
                next_cur <= edge_cur;
            end
        end else begin
            case (state)
                REQ: begin
                    en_ins_read <= 1'b0;
                    state       <= CAPT;
                end
                CAPT: begin
                    state    <= EMIT;
                    op_valid <= 1'b1;
                    if (sum_d == cur_x) begin
                        op       <= diag_op;
                        next_cur <= diag;
                    end else if (sum_u == cur_x) begin
                        op       <= OP_UP;
                        next_cur <= up;
                    end else if (sum_l == cur_x) begin
                        op       <= OP_LEFT;
                        next_cur <= left;
                    end else begin
                        err      <= 1'b1;
                        op       <= diag_op;
                        next_cur <= diag;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_traceback_unit.sv
// Directed bench for traceback_unit: a small score-RAM/char-ROM model feeds the DUT,
// expected ops go into a queue and a monitor compares them at each handshake.
module tb_traceback_unit;
    localparam int IW = 8;

    logic              clk = 1'b0;
    logic              rst, start, op_ready;
    logic [IW-1:0]     len_a, len_b;
    logic signed [8:0] score_in, diag, up, left;
    logic              en_ins_read, we, op_valid, busy, done, err;
    logic [IW-1:0]     i, j, addr_a, addr_b;
    logic [1:0]        char_a, char_b, op;

    logic signed [8:0] hmem [0:3][0:3];
    logic [1:0]        seqa [0:3];
    logic [1:0]        seqb [0:3];

    int         total = 0;
    int         bad = 0;
    int         rd_count = 0;
    logic [1:0] exp_q [$];

    always #5 clk = ~clk;

    traceback_unit dut (
        .clk(clk), .rst(rst), .start(start), .len_a(len_a), .len_b(len_b),
        .score_in(score_in), .en_ins_read(en_ins_read), .we(we), .i(i), .j(j),
        .diag(diag), .up(up), .left(left), .addr_a(addr_a), .addr_b(addr_b),
        .char_a(char_a), .char_b(char_b), .op(op), .op_valid(op_valid),
        .op_ready(op_ready), .busy(busy), .done(done), .err(err)
    );

    // Score RAM and sequence ROMs, both with one cycle of read latency.
    always @(posedge clk) begin
        if (en_ins_read) begin
            diag <= hmem[i[1:0] - 2'd1][j[1:0] - 2'd1];
            up   <= hmem[i[1:0] - 2'd1][j[1:0]];
            left <= hmem[i[1:0]][j[1:0] - 2'd1];
        end
        char_a <= seqa[addr_a[1:0]];
        char_b <= seqb[addr_b[1:0]];
    end

    task automatic check_output(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every accepted op is popped against the scoreboard.
    always @(negedge clk) begin
        if (en_ins_read) rd_count++;
        if (!rst && op_valid && op_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_op: got %0d expected none", op);
            end else begin
                check_output("op", int'(op), int'(exp_q.pop_front()));
            end
        end
    end

    task automatic apply_stimulus(input int la, input int lb, input int sc,
                                  input int nops, input logic [1:0] o0, input logic [1:0] o1);
        if (nops > 0) exp_q.push_back(o0);
        if (nops > 1) exp_q.push_back(o1);
        @(posedge clk); #1;
        len_a = IW'(la); len_b = IW'(lb); score_in = 9'(sc); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int seen = 0;
        for (int k = 0; k < 300 && seen == 0; k++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        check_output({name, "_done"}, seen, 1);
        if (seen != 0) begin
            check_output({name, "_busy_at_done"}, int'(busy), 0);
            @(negedge clk);
            check_output({name, "_done_pulse"}, int'(done), 0);
        end
    endtask

    task automatic set_cell11(input int h00, input int h01, input int h10,
                              input logic [1:0] ca, input logic [1:0] cb);
        hmem[0][0] = 9'(h00); hmem[0][1] = 9'(h01); hmem[1][0] = 9'(h10);
        seqa[0] = ca; seqb[0] = cb;
    endtask

    initial begin
        int        stall_ok;
        logic [1:0] hold_op;
        logic [IW-1:0] hold_i, hold_j;
        int        seen;

        rst = 1'b1; start = 1'b0; op_ready = 1'b1;
        len_a = '0; len_b = '0; score_in = '0;
        diag = '0; up = '0; left = '0;
        for (int r = 0; r < 4; r++) begin
            seqa[r] = 2'd0; seqb[r] = 2'd0;
            for (int c = 0; c < 4; c++) hmem[r][c] = '0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_output("rst_busy", int'(busy), 0);
        check_output("rst_done", int'(done), 0);
        check_output("rst_op_valid", int'(op_valid), 0);
        check_output("rst_rd", int'(en_ins_read), 0);
        check_output("rst_err", int'(err), 0);
        check_output("rst_ij", int'({i, j}), 0);
        check_output("rst_we", int'(we), 0);

        $display("[TB] 1x1 diagonal match");
        set_cell11(0, -1, -1, 2'd0, 2'd0);
        apply_stimulus(1, 1, 1, 1, 2'b00, 2'b00);
        check_output("busy_after_start", int'(busy), 1);
        wait_done("match11");
        check_output("match11_err", int'(err), 0);

        $display("[TB] 2x0 up-only edge walk");
        rd_count = 0;
        apply_stimulus(2, 0, -2, 2, 2'b10, 2'b10);
        wait_done("up20");
        check_output("up20_no_ram_read", rd_count, 0);

        $display("[TB] empty sequences");
        apply_stimulus(0, 0, 0, 0, 2'b00, 2'b00);
        wait_done("empty");

        $display("[TB] tie resolved by diagonal priority");
        set_cell11(0, 0, 0, 2'd0, 2'd1);
        apply_stimulus(1, 1, -1, 1, 2'b01, 2'b00);
        wait_done("tie");
        check_output("tie_err", int'(err), 0);

        $display("[TB] 1x2 with consumer stall");
        hmem[0][0] = 9'sd0;  hmem[0][1] = -9'sd1; hmem[0][2] = -9'sd2;
        hmem[1][0] = -9'sd1; hmem[1][1] = -9'sd1; hmem[1][2] = 9'sd0;
        seqa[0] = 2'd0; seqb[0] = 2'd1; seqb[1] = 2'd0;
        op_ready = 1'b0;
        apply_stimulus(1, 2, 0, 2, 2'b00, 2'b11);
        seen = 0;
        for (int k = 0; k < 50 && seen == 0; k++) begin
            @(negedge clk);
            if (op_valid) seen = 1;
        end
        check_output("stall_op_valid_seen", seen, 1);
        hold_op = op; hold_i = i; hold_j = j;
        stall_ok = 1;
        repeat (5) begin
            @(negedge clk);
            if (!op_valid || op != hold_op || i != hold_i || j != hold_j) stall_ok = 0;
        end
        check_output("stall_stable", stall_ok, 1);
        check_output("stall_ij", int'({hold_i, hold_j}), int'({8'd1, 8'd2}));
        @(posedge clk); #1 op_ready = 1'b1;
        wait_done("stall12");

        $display("[TB] inconsistent RAM sets sticky err");
        set_cell11(0, 0, 0, 2'd0, 2'd0);
        apply_stimulus(1, 1, 5, 1, 2'b00, 2'b00);
        wait_done("err11");
        check_output("err_set", int'(err), 1);
        repeat (3) @(negedge clk);
        check_output("err_sticky", int'(err), 1);
        apply_stimulus(2, 0, -2, 2, 2'b10, 2'b10);
        @(negedge clk);
        check_output("err_cleared_on_start", int'(err), 0);
        wait_done("err_clear_run");

        $display("[TB] reset aborts a traceback");
        hmem[0][0] = 9'sd0;  hmem[0][1] = -9'sd1; hmem[0][2] = -9'sd2;
        hmem[1][0] = -9'sd1; hmem[1][1] = 9'sd1;  hmem[1][2] = 9'sd0;
        hmem[2][0] = -9'sd2; hmem[2][1] = 9'sd0;  hmem[2][2] = 9'sd0;
        seqa[0] = 2'd0; seqa[1] = 2'd1; seqb[0] = 2'd0; seqb[1] = 2'd2;
        op_ready = 1'b0;
        apply_stimulus(2, 2, 0, 0, 2'b00, 2'b00);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        check_output("abort_busy", int'(busy), 0);
        check_output("abort_op_valid", int'(op_valid), 0);
        check_output("abort_done", int'(done), 0);
        check_output("abort_ij", int'({i, j}), 0);
        @(negedge clk);
        check_output("abort_no_done", int'(done), 0);
        op_ready = 1'b1;

        $display("[TB] full 2x2 run, start while busy ignored");
        apply_stimulus(2, 2, 0, 2, 2'b01, 2'b00);
        @(posedge clk); #1;
        len_a = 8'd1; len_b = 8'd0; score_in = 9'sd3; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done("run22");
        repeat (6) @(negedge clk);
        check_output("queue_drained", exp_q.size(), 0);
        check_output("final_idle_busy", int'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
